// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Two-port arbiter in front of the single-port synchronous data
//                memory. Port C (core load/store) has fixed priority. Port D
//                (DMA/debug) is force-granted once it has been refused
//                MAX_WAIT cycles in a row. One access is issued per cycle.
//                Read data comes back one cycle after the grant and is steered
//                to the port that issued the read.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    ADDR_WIDTH  byte-address width of the data memory (>= 3)
//    MAX_WAIT    refused cycles after which D wins over C (>= 1)
//  Ports
//    clk, rst                 clock; asynchronous active-high reset
//    c_req_i/c_we_i/c_addr_i/c_wdata_i/c_be_i
//                             core request (held until c_gnt_o)
//    c_gnt_o                  core request accepted this cycle (combinational)
//    c_rvalid_o/c_rdata_o     core read response (rdata is 0 when not valid)
//    d_*                      DMA/debug port, same set and meaning as c_*
//    mem_re_o/mem_we_o        memory read / write strobes
//    mem_addr_o               word-aligned memory address
//    mem_wdata_o/mem_be_o     memory write data / byte enables
//    mem_rdata_i              memory read data, valid the cycle after mem_re_o
//  Build option
//    DMEM_ARB_PERF_EN         adds conflict_cnt_o and dstarve_cnt_o counters
// ============================================================================
module dmem_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    // core port
    input  logic                  c_req_i,
    input  logic                  c_we_i,
    input  logic [ADDR_WIDTH-1:0] c_addr_i,
    input  logic [31:0]           c_wdata_i,
    input  logic [3:0]            c_be_i,
    output logic                  c_gnt_o,
    output logic                  c_rvalid_o,
    output logic [31:0]           c_rdata_o,
    // DMA / debug port
    input  logic                  d_req_i,
    input  logic                  d_we_i,
    input  logic [ADDR_WIDTH-1:0] d_addr_i,
    input  logic [31:0]           d_wdata_i,
    input  logic [3:0]            d_be_i,
    output logic                  d_gnt_o,
    output logic                  d_rvalid_o,
    output logic [31:0]           d_rdata_o,
`ifdef DMEM_ARB_PERF_EN
    // performance counters
    output logic [31:0]           conflict_cnt_o,
    output logic [31:0]           dstarve_cnt_o,
`endif
    // memory side
    output logic                  mem_re_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]           mem_wdata_o,
    output logic [3:0]            mem_be_o,
    input  logic [31:0]           mem_rdata_i
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int                c_WAIT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [c_WAIT_W-1:0] c_MAX_WAIT = c_WAIT_W'(MAX_WAIT);

    // Owner of the read whose data arrives from memory in the current cycle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_C    = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [c_WAIT_W-1:0] r_wait_cnt;
    owner_t              r_rd_owner;
    logic                r_c_rvalid;
    logic                r_d_rvalid;

    // ------------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------------
    logic w_starved;
    logic w_c_gnt;
    logic w_d_gnt;
    logic w_conflict;

    // The counter saturates at MAX_WAIT, so equality is the starvation test.
    assign w_starved  = (r_wait_cnt == c_MAX_WAIT);
    assign w_conflict = c_req_i & d_req_i;

    // Grants are masked while reset is held so that no access reaches the
    // memory during reset even if a requester keeps its request up.
    assign w_c_gnt = ~rst & c_req_i & ~(d_req_i & w_starved);
    assign w_d_gnt = ~rst & d_req_i & ~w_c_gnt;

    assign c_gnt_o = w_c_gnt;
    assign d_gnt_o = w_d_gnt;

    // ------------------------------------------------------------------------
    // Memory request mux. Everything is zero when nobody is granted.
    // ------------------------------------------------------------------------
    always_comb begin
        mem_re_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        if (w_c_gnt) begin
            mem_re_o    = ~c_we_i;
            mem_we_o    = c_we_i;
            mem_addr_o  = {c_addr_i[ADDR_WIDTH-1:2], 2'b00};
            mem_wdata_o = c_wdata_i;
            mem_be_o    = c_be_i;
        end else if (w_d_gnt) begin
            mem_re_o    = ~d_we_i;
            mem_we_o    = d_we_i;
            mem_addr_o  = {d_addr_i[ADDR_WIDTH-1:2], 2'b00};
            mem_wdata_o = d_wdata_i;
            mem_be_o    = d_be_i;
        end
    end

    // Byte-lane bits of the request address are not used by a word memory.
    logic w_unused_addr_lsbs;
    assign w_unused_addr_lsbs = ^{c_addr_i[1:0], d_addr_i[1:0]};

    // ------------------------------------------------------------------------
    // Read-owner tracking and starvation counter.
    // rvalid flags are registered alongside the owner so the response
    // strobes come straight from flops.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= '0;
            r_rd_owner <= OWN_NONE;
            r_c_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
        end else begin
            // Owner of next cycle's memory read data
            if (w_c_gnt && !c_we_i) begin
                r_rd_owner <= OWN_C;
                r_c_rvalid <= 1'b1;
                r_d_rvalid <= 1'b0;
            end else if (w_d_gnt && !d_we_i) begin
                r_rd_owner <= OWN_D;
                r_c_rvalid <= 1'b0;
                r_d_rvalid <= 1'b1;
            end else begin
                r_rd_owner <= OWN_NONE;
                r_c_rvalid <= 1'b0;
                r_d_rvalid <= 1'b0;
            end

            // Counts consecutive refused D cycles, saturating at MAX_WAIT.
            if (!d_req_i || w_d_gnt) begin
                r_wait_cnt <= '0;
            end else if (r_wait_cnt != c_MAX_WAIT) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read response steering
    // ------------------------------------------------------------------------
    assign c_rvalid_o = r_c_rvalid;
    assign d_rvalid_o = r_d_rvalid;
    assign c_rdata_o  = r_c_rvalid ? mem_rdata_i : 32'h0;
    assign d_rdata_o  = r_d_rvalid ? mem_rdata_i : 32'h0;

    // The owner encoding mirrors the rvalid flags; it is kept as a readable
    // debug/state view of where the in-flight read belongs.
    logic w_unused_owner;
    assign w_unused_owner = ^r_rd_owner;

`ifdef DMEM_ARB_PERF_EN
    // ------------------------------------------------------------------------
    // Performance counters (wrap naturally at 2^32)
    // ------------------------------------------------------------------------
    logic        w_forced_d;
    logic [31:0] r_conflict_cnt;
    logic [31:0] r_dstarve_cnt;

    // A forced grant is a D grant taken while C was also asking.
    assign w_forced_d = w_d_gnt & c_req_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_conflict_cnt <= 32'h0;
            r_dstarve_cnt  <= 32'h0;
        end else begin
            if (w_conflict) begin
                r_conflict_cnt <= r_conflict_cnt + 32'h1;
            end
            if (w_forced_d) begin
                r_dstarve_cnt <= r_dstarve_cnt + 32'h1;
            end
        end
    end

    assign conflict_cnt_o = r_conflict_cnt;
    assign dstarve_cnt_o  = r_dstarve_cnt;
`else
    logic w_unused_conflict;
    assign w_unused_conflict = w_conflict;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Self-checking bench for dmem_arbiter. Directed scenarios plus
//                a randomized run checked against a transaction-level model
//                that owns its own copy of the memory contents.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int ADDR_WIDTH = 10;
    localparam int MAX_WAIT   = 4;
    localparam int WORDS      = 1 << (ADDR_WIDTH - 2);

    logic                  clk;
    logic                  rst;
    logic                  c_req_i, c_we_i, d_req_i, d_we_i;
    logic [ADDR_WIDTH-1:0] c_addr_i, d_addr_i;
    logic [31:0]           c_wdata_i, d_wdata_i;
    logic [3:0]            c_be_i, d_be_i;
    logic                  c_gnt_o, c_rvalid_o, d_gnt_o, d_rvalid_o;
    logic [31:0]           c_rdata_o, d_rdata_o;
    logic                  mem_re_o, mem_we_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [31:0]           mem_wdata_o, mem_rdata_i;
    logic [3:0]            mem_be_o;
`ifdef DMEM_ARB_PERF_EN
    logic [31:0]           conflict_cnt_o, dstarve_cnt_o;
`endif

    int total = 0;
    int bad   = 0;

    dmem_arbiter #(.ADDR_WIDTH(ADDR_WIDTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .c_req_i(c_req_i), .c_we_i(c_we_i), .c_addr_i(c_addr_i),
        .c_wdata_i(c_wdata_i), .c_be_i(c_be_i), .c_gnt_o(c_gnt_o),
        .c_rvalid_o(c_rvalid_o), .c_rdata_o(c_rdata_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i),
        .d_wdata_i(d_wdata_i), .d_be_i(d_be_i), .d_gnt_o(d_gnt_o),
        .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
`ifdef DMEM_ARB_PERF_EN
        .conflict_cnt_o(conflict_cnt_o), .dstarve_cnt_o(dstarve_cnt_o),
`endif
        .mem_re_o(mem_re_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory behind the arbiter ----------------
    logic        pl_en;
    logic [7:0]  pl_addr;
    logic [31:0] pl_data;
    logic [31:0] mem [WORDS];
    logic [31:0] mem_rd;
    logic [31:0] exp_mem [WORDS];   // bench's own view of memory contents

    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (mem_we_o) begin
            for (int b = 0; b < 4; b++)
                if (mem_be_o[b]) mem[mem_addr_o[9:2]][b*8 +: 8] <= mem_wdata_o[b*8 +: 8];
        end
        if (mem_re_o) mem_rd <= mem[mem_addr_o[9:2]];
    end
    assign mem_rdata_i = mem_rd;

    task automatic idle_reqs();
        c_req_i = 0; c_we_i = 0; c_addr_i = '0; c_wdata_i = '0; c_be_i = '0;
        d_req_i = 0; d_we_i = 0; d_addr_i = '0; d_wdata_i = '0; d_be_i = '0;
    endtask

    task automatic preload();
        for (int i = 0; i < WORDS; i++) begin
            @(negedge clk);
            pl_en = 1; pl_addr = 8'(i);
            pl_data = (i == 4) ? 32'hDEADBEEF : $urandom;
            exp_mem[i] = pl_data;
        end
        @(negedge clk);
        pl_en = 0;
    endtask

    // ---------------- directed scenarios ----------------
    task automatic test_reset();
        @(negedge clk);
        c_req_i = 1; c_we_i = 0; c_addr_i = 10'h000;
        #1;
        total++;
        if ({c_gnt_o, d_gnt_o, mem_re_o, mem_we_o, c_rvalid_o, d_rvalid_o} !== 6'b0) begin
            bad++;
            $display("FAIL reset_quiet got=%b exp=000000",
                     {c_gnt_o, d_gnt_o, mem_re_o, mem_we_o, c_rvalid_o, d_rvalid_o});
        end
`ifdef DMEM_ARB_PERF_EN
        total++;
        if ({conflict_cnt_o, dstarve_cnt_o} !== 64'h0) begin
            bad++;
            $display("FAIL reset_counters got=%h/%h exp=0/0", conflict_cnt_o, dstarve_cnt_o);
        end
`endif
        @(negedge clk);
        rst = 0;
        #1;
        total++;
        if (c_gnt_o !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_gnt got=%b exp=1", c_gnt_o);
        end
        @(negedge clk);
        idle_reqs();
        @(negedge clk);
    endtask

    task automatic test_c_read();
        @(negedge clk);
        c_req_i = 1; c_we_i = 0; c_addr_i = 10'h013; c_be_i = 4'hF;
        #1;
        total++;
        if ({c_gnt_o, d_gnt_o, mem_re_o, mem_we_o, mem_addr_o} !== {4'b1010, 10'h010}) begin
            bad++;
            $display("FAIL c_read_issue got=%b/%h exp=1010/010",
                     {c_gnt_o, d_gnt_o, mem_re_o, mem_we_o}, mem_addr_o);
        end
        @(negedge clk);
        c_req_i = 0;
        #1;
        total++;
        if ({c_rvalid_o, c_rdata_o, d_rvalid_o, d_rdata_o} !== {1'b1, 32'hDEADBEEF, 1'b0, 32'h0}) begin
            bad++;
            $display("FAIL c_read_resp got=%b/%h d=%b/%h exp=1/deadbeef d=0/0",
                     c_rvalid_o, c_rdata_o, d_rvalid_o, d_rdata_o);
        end
    endtask

    task automatic test_d_write();
        @(negedge clk);
        d_req_i = 1; d_we_i = 1; d_addr_i = 10'h020; d_be_i = 4'b0011; d_wdata_i = 32'h1234;
        #1;
        total++;
        if ({c_gnt_o, d_gnt_o, mem_re_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o}
            !== {4'b0101, 4'b0011, 10'h020, 32'h1234}) begin
            bad++;
            $display("FAIL d_write_issue got=%b be=%b a=%h wd=%h exp=0101 be=0011 a=020 wd=1234",
                     {c_gnt_o, d_gnt_o, mem_re_o, mem_we_o}, mem_be_o, mem_addr_o, mem_wdata_o);
        end
        exp_mem[8][15:0] = 16'h1234;
        @(negedge clk);
        idle_reqs();
        #1;
        total++;
        if ({d_rvalid_o, c_rvalid_o} !== 2'b00) begin
            bad++;
            $display("FAIL d_write_no_resp got=%b exp=00", {d_rvalid_o, c_rvalid_o});
        end
    endtask

    task automatic test_contention();
        logic [9:0] d_turn;
        d_turn = 10'b1000010000;   // bit i set: D wins cycle i
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            c_req_i = 1; c_we_i = 0; c_addr_i = 10'h100;
            d_req_i = 1; d_we_i = 0; d_addr_i = 10'h200;
            #1;
            total++;
            if ({c_gnt_o, d_gnt_o} !== {~d_turn[i], d_turn[i]}) begin
                bad++;
                $display("FAIL contention_cycle%0d got=%b exp=%b", i,
                         {c_gnt_o, d_gnt_o}, {~d_turn[i], d_turn[i]});
            end
        end
        @(negedge clk);
        idle_reqs();
        #1;
`ifdef DMEM_ARB_PERF_EN
        total++;
        if ({conflict_cnt_o, dstarve_cnt_o} !== {32'd10, 32'd2}) begin
            bad++;
            $display("FAIL contention_counters got=%0d/%0d exp=10/2", conflict_cnt_o, dstarve_cnt_o);
        end
`endif
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        c_req_i = 1; c_we_i = 0; c_addr_i = 10'h044;
        #1;
        total++;
        if (c_gnt_o !== 1'b1) begin
            bad++;
            $display("FAIL b2b_c_gnt got=%b exp=1", c_gnt_o);
        end
        @(negedge clk);
        c_req_i = 0;
        d_req_i = 1; d_we_i = 0; d_addr_i = 10'h088;
        #1;
        total++;
        if ({c_rvalid_o, c_rdata_o, d_gnt_o, d_rvalid_o} !== {1'b1, exp_mem[8'h11], 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL b2b_c_resp got=%b/%h dg=%b dv=%b exp=1/%h dg=1 dv=0",
                     c_rvalid_o, c_rdata_o, d_gnt_o, d_rvalid_o, exp_mem[8'h11]);
        end
        @(negedge clk);
        d_req_i = 0;
        #1;
        total++;
        if ({d_rvalid_o, d_rdata_o, c_rvalid_o, c_rdata_o} !== {1'b1, exp_mem[8'h22], 1'b0, 32'h0}) begin
            bad++;
            $display("FAIL b2b_d_resp got=%b/%h c=%b/%h exp=1/%h c=0/0",
                     d_rvalid_o, d_rdata_o, c_rvalid_o, c_rdata_o, exp_mem[8'h22]);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk);
        c_req_i = 1; c_we_i = 0; c_addr_i = 10'h030;
        d_req_i = 1; d_we_i = 0; d_addr_i = 10'h034;   // make counters non-zero
        #1;
        total++;
        if (c_gnt_o !== 1'b1) begin
            bad++;
            $display("FAIL midrst_gnt got=%b exp=1", c_gnt_o);
        end
        @(posedge clk);
        #1;
        rst = 1;
        #1;
        total++;
        if ({c_rvalid_o, c_rdata_o, c_gnt_o, d_gnt_o} !== 35'h0) begin
            bad++;
            $display("FAIL midrst_drop got=%b/%h g=%b%b exp=0/0 g=00",
                     c_rvalid_o, c_rdata_o, c_gnt_o, d_gnt_o);
        end
        @(negedge clk);
        idle_reqs();
        #1;
`ifdef DMEM_ARB_PERF_EN
        total++;
        if ({conflict_cnt_o, dstarve_cnt_o} !== 64'h0) begin
            bad++;
            $display("FAIL midrst_counters got=%h/%h exp=0/0", conflict_cnt_o, dstarve_cnt_o);
        end
`endif
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        #1;
        total++;
        if ({c_rvalid_o, d_rvalid_o} !== 2'b00) begin
            bad++;
            $display("FAIL midrst_after got=%b exp=00", {c_rvalid_o, d_rvalid_o});
        end
    endtask

    // ---------------- randomized run against a transaction model ----------
    task automatic test_random(input int n);
        int          m_wait  = 0;   // consecutive refused D cycles
        int          m_owner = 0;   // 0 none, 1 C, 2 D: who gets this cycle's data
        logic [31:0] m_rdata = 0;
        logic        c_done = 0, d_done = 0;
        logic        e_cg, e_dg, e_re, e_we;
        logic [ADDR_WIDTH-1:0] e_addr;
        logic [31:0] e_wd;
        logic [3:0]  e_be;
        int          w;
        for (int cyc = 0; cyc < n; cyc++) begin
            @(negedge clk);
            if (c_done) c_req_i = 0;
            if (d_done) d_req_i = 0;
            if (!c_req_i && $urandom_range(0, 9) < 6) begin
                c_req_i = 1; c_we_i = 1'($urandom); c_addr_i = ADDR_WIDTH'($urandom);
                c_wdata_i = $urandom; c_be_i = 4'($urandom);
            end
            if (!d_req_i && $urandom_range(0, 9) < 6) begin
                d_req_i = 1; d_we_i = 1'($urandom); d_addr_i = ADDR_WIDTH'($urandom);
                d_wdata_i = $urandom; d_be_i = 4'($urandom);
            end
            #1;
            // who wins this cycle
            e_cg = 0; e_dg = 0;
            if (c_req_i && d_req_i) begin
                if (m_wait >= MAX_WAIT) e_dg = 1; else e_cg = 1;
            end else if (c_req_i) e_cg = 1;
            else if (d_req_i) e_dg = 1;
            e_re = (e_cg && !c_we_i) || (e_dg && !d_we_i);
            e_we = (e_cg && c_we_i) || (e_dg && d_we_i);
            e_addr = e_cg ? c_addr_i : d_addr_i;
            e_addr[1:0] = 2'b00;
            e_wd = e_cg ? c_wdata_i : d_wdata_i;
            e_be = e_cg ? c_be_i : d_be_i;

            total++;
            if ({c_gnt_o, d_gnt_o, mem_re_o, mem_we_o} !== {e_cg, e_dg, e_re, e_we}) begin
                bad++;
                $display("FAIL rand_grant cyc%0d got=%b exp=%b", cyc,
                         {c_gnt_o, d_gnt_o, mem_re_o, mem_we_o}, {e_cg, e_dg, e_re, e_we});
            end
            if (e_cg || e_dg) begin
                total++;
                if ({mem_addr_o, mem_wdata_o, mem_be_o} !== {e_addr, e_wd, e_be}) begin
                    bad++;
                    $display("FAIL rand_payload cyc%0d got=%h/%h/%h exp=%h/%h/%h", cyc,
                             mem_addr_o, mem_wdata_o, mem_be_o, e_addr, e_wd, e_be);
                end
            end
            total++;
            if ({c_rvalid_o, c_rdata_o} !== {m_owner == 1, (m_owner == 1) ? m_rdata : 32'h0}) begin
                bad++;
                $display("FAIL rand_c_resp cyc%0d got=%b/%h exp=%b/%h", cyc, c_rvalid_o, c_rdata_o,
                         m_owner == 1, (m_owner == 1) ? m_rdata : 32'h0);
            end
            total++;
            if ({d_rvalid_o, d_rdata_o} !== {m_owner == 2, (m_owner == 2) ? m_rdata : 32'h0}) begin
                bad++;
                $display("FAIL rand_d_resp cyc%0d got=%b/%h exp=%b/%h", cyc, d_rvalid_o, d_rdata_o,
                         m_owner == 2, (m_owner == 2) ? m_rdata : 32'h0);
            end

            // advance the model to the next cycle
            if (d_req_i && !e_dg) m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
            else m_wait = 0;
            m_owner = 0;
            w = int'(e_addr) / 4;
            if (e_re) begin
                m_owner = e_cg ? 1 : 2;
                m_rdata = exp_mem[w];
            end
            if (e_we)
                for (int b = 0; b < 4; b++)
                    if (e_be[b]) exp_mem[w][b*8 +: 8] = e_wd[b*8 +: 8];
            c_done = e_cg;
            d_done = e_dg;
        end
        @(negedge clk);
        idle_reqs();
        @(negedge clk);
    endtask

    initial begin
        rst = 1;
        pl_en = 0; pl_addr = '0; pl_data = '0;
        idle_reqs();
        preload();
        test_reset();
        test_c_read();
        test_d_write();
        test_contention();
        test_back_to_back();
        test_random(600);
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
